// File: rtl/wb_uart_echo_ctrl.sv
// Wishbone master that programs a UART16550 and then echoes every received byte
// back to its transmitter through a small internal FIFO; a stalled bus halts it.
module wb_uart_echo_ctrl #(
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VALUE = 8'h03,
    parameter int          BUF_DEPTH = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    output logic [4:0]  WB_ADR_O,
    output logic [31:0] WB_DAT_O,
    input  logic [31:0] WB_DAT_I,
    output logic [3:0]  WB_SEL_O,
    output logic        WB_CYC_O,
    output logic        WB_STB_O,
    output logic        WB_WE_O,
    input  logic        WB_ACK_I,
    output logic        CONFIG_DONE,
    output logic        ERROR,
    output logic        LINE_ERR,
    output logic [15:0] ECHO_COUNT
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [4:0]    ADR_DATA = 5'd0;
    localparam logic [4:0]    ADR_LSR  = 5'd5;
    localparam logic [2:0]    CFG_LAST = 3'd5;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1'b1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1'b1);

    typedef enum logic [2:0] {
        ST_CFG   = 3'd0,
        ST_GAP   = 3'd1,
        ST_POLL  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    // Configuration step -> {register address, data}.
    function automatic logic [12:0] cfg_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_entry = {5'd3, 8'h83};
            3'd1:    cfg_entry = {5'd0, DIVISOR[7:0]};
            3'd2:    cfg_entry = {5'd1, DIVISOR[15:8]};
            3'd3:    cfg_entry = {5'd3, LCR_VALUE};
            3'd4:    cfg_entry = {5'd2, 8'h07};
            default: cfg_entry = {5'd1, 8'h00};
        endcase
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        case (lane)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
    endfunction

    state_t        state_q, state_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [4:0]    adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [2:0]    cfg_idx_q, cfg_idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          lerr_q, lerr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW:0]   head_q, head_d;
    logic [AW:0]   tail_q, tail_d;
    logic [7:0]    mem_q [BUF_DEPTH];

    logic          push_s;
    logic          launch_s;
    logic          l_we_s;
    logic [4:0]    l_adr_s;
    logic [7:0]    l_dat_s;
    logic [7:0]    rd_byte_s;
    logic [7:0]    head_byte_s;
    logic          empty_s;
    logic          full_s;

    assign rd_byte_s   = lane_byte(WB_DAT_I, adr_q[1:0]);
    assign head_byte_s = mem_q[head_q[AW-1:0]];
    assign empty_s     = (head_q == tail_q);
    assign full_s      = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);

    // Next-state logic: completes the access in flight, otherwise launches the next one.
    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cfg_idx_d = cfg_idx_q;
        tmo_d     = tmo_q;
        done_d    = done_q;
        err_d     = err_q;
        lerr_d    = lerr_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        push_s    = 1'b0;
        launch_s  = 1'b0;
        l_we_s    = 1'b0;
        l_adr_s   = 5'd0;
        l_dat_s   = 8'h00;

        if (stb_q) begin
            if (WB_ACK_I) begin
                stb_d = 1'b0;
                tmo_d = '0;
                case (state_q)
                    ST_CFG: begin
                        if (cfg_idx_q == CFG_LAST) begin
                            done_d    = 1'b1;
                            cfg_idx_d = 3'd0;
                            state_d   = ST_GAP;
                        end else begin
                            cfg_idx_d = cfg_idx_q + 3'd1;
                        end
                    end
                    ST_POLL: begin
                        lerr_d = lerr_q | (|rd_byte_s[4:1]);
                        // Draining the FIFO wins over refilling it.
                        if (rd_byte_s[5] && !empty_s) begin
                            state_d = ST_WRITE;
                        end else if (rd_byte_s[0] && !full_s) begin
                            state_d = ST_READ;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                    ST_READ: begin
                        push_s  = 1'b1;
                        tail_d  = tail_q + PTR_ONE;
                        state_d = ST_GAP;
                    end
                    ST_WRITE: begin
                        head_d  = head_q + PTR_ONE;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = ST_GAP;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end else if (tmo_q == TMO_LAST) begin
                stb_d   = 1'b0;
                err_d   = 1'b1;
                state_d = ST_HALT;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end else begin
            case (state_q)
                ST_CFG: begin
                    launch_s           = 1'b1;
                    l_we_s             = 1'b1;
                    {l_adr_s, l_dat_s} = cfg_entry(cfg_idx_q);
                end
                ST_GAP: begin
                    if (ENABLE) begin
                        launch_s = 1'b1;
                        l_adr_s  = ADR_LSR;
                        state_d  = ST_POLL;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_READ: begin
                    launch_s = 1'b1;
                    l_adr_s  = ADR_DATA;
                end
                ST_WRITE: begin
                    launch_s = 1'b1;
                    l_we_s   = 1'b1;
                    l_adr_s  = ADR_DATA;
                    l_dat_s  = head_byte_s;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_GAP;
                end
            endcase

            if (launch_s) begin
                stb_d = 1'b1;
                we_d  = l_we_s;
                adr_d = l_adr_s;
                dat_d = l_dat_s;
                sel_d = 4'b0001 << l_adr_s[1:0];
                tmo_d = '0;
            end else begin
                stb_d = 1'b0;
            end
        end
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_CFG;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 5'd0;
            dat_q     <= 8'h00;
            sel_q     <= 4'b0000;
            cfg_idx_q <= 3'd0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lerr_q    <= 1'b0;
            cnt_q     <= 16'd0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cfg_idx_q <= cfg_idx_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            err_q     <= err_d;
            lerr_q    <= lerr_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    // Echo FIFO storage; validity is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[tail_q[AW-1:0]] <= rd_byte_s;
        end
    end

    assign WB_CYC_O    = stb_q;
    assign WB_STB_O    = stb_q;
    assign WB_WE_O     = we_q;
    assign WB_ADR_O    = adr_q;
    assign WB_DAT_O    = {4{dat_q}};
    assign WB_SEL_O    = sel_q;
    assign CONFIG_DONE = done_q;
    assign ERROR       = err_q;
    assign LINE_ERR    = lerr_q;
    assign ECHO_COUNT  = cnt_q;

endmodule

// File: tb/tb_wb_uart_echo_ctrl.sv
// Bench for wb_uart_echo_ctrl: a Wishbone slave models the UART registers and
// every access is logged, then each scenario task checks the log against the rules.
module tb_wb_uart_echo_ctrl;
    localparam int          BUF_DEPTH = 4;
    localparam int          TIMEOUT   = 255;
    localparam logic [15:0] DIV       = 16'd27;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic        ack = 1'b0;
    logic        done, err, lerr;
    logic [15:0] echo_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  adr;
        logic [31:0] dw;
        logic [3:0]  sel;
        logic [7:0]  rd;
    } acc_t;

    acc_t       log_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_load_q[$];

    bit         mute = 1'b0;
    bit         rand_wait = 1'b0;
    bit         force_en = 1'b0;
    int         wait_n = 0;
    logic [7:0] force_lsr = 8'h00;
    logic [7:0] rbr_seed = 8'h00;

    logic [7:0] rbr_ctr;
    bit         in_acc = 1'b0;
    bit         dlab = 1'b0;
    int         wcnt = 0;
    int         cur_wait = 0;
    acc_t       s_e;
    logic [7:0] s_b;

    wb_uart_echo_ctrl #(
        .DIVISOR(DIV), .LCR_VALUE(8'h03), .BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .RESET(rst_n), .ENABLE(enable),
        .WB_ADR_O(adr), .WB_DAT_O(dat_o), .WB_DAT_I(dat_i), .WB_SEL_O(sel),
        .WB_CYC_O(cyc), .WB_STB_O(stb), .WB_WE_O(we), .WB_ACK_I(ack),
        .CONFIG_DONE(done), .ERROR(err), .LINE_ERR(lerr), .ECHO_COUNT(echo_cnt)
    );

    always #5 clk = ~clk;

    // UART register model acting as the Wishbone slave, driven on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack = 1'b0; in_acc = 1'b0; dlab = 1'b0; rbr_ctr = rbr_seed;
            log_q.delete(); tx_q.delete(); rx_q = rx_load_q;
        end else if (ack) begin
            ack = 1'b0;
        end else if (cyc && stb && !mute) begin
            if (!in_acc) begin
                in_acc = 1'b1; wcnt = 0;
                cur_wait = rand_wait ? int'($urandom_range(0, 2)) : wait_n;
            end
            if (wcnt >= cur_wait) begin
                s_e.we = we; s_e.adr = adr; s_e.dw = dat_o; s_e.sel = sel; s_b = 8'h00;
                if (we) begin
                    if (adr == 5'd3) dlab = dat_o[7];
                    else if (adr == 5'd0 && !dlab) tx_q.push_back(dat_o[7:0]);
                end else if (adr == 5'd5) begin
                    if (force_en) s_b = force_lsr;
                    else begin
                        s_b[5] = ($urandom_range(0, 1) == 1);
                        s_b[0] = (rx_q.size() != 0);
                    end
                end else if (adr == 5'd0) begin
                    if (force_en) begin s_b = rbr_ctr; rbr_ctr = rbr_ctr + 8'd1; end
                    else if (rx_q.size() != 0) s_b = rx_q.pop_front();
                end
                s_e.rd = s_b;
                dat_i = $urandom();
                dat_i[8*int'(adr[1:0]) +: 8] = s_b;
                log_q.push_back(s_e);
                ack = 1'b1; in_acc = 1'b0;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // 0 = LSR read, 1 = RBR read, 2 = THR write, 3 = anything else
    function automatic int kind_of(input acc_t e);
        if (!e.we && e.adr == 5'd5) return 0;
        if (!e.we && e.adr == 5'd0) return 1;
        if (e.we && e.adr == 5'd0) return 2;
        return 3;
    endfunction

    task automatic do_reset(input bit en);
        rst_n = 1'b0;
        enable = en;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) tick();
        checks++; if ({cyc, stb, we} !== 3'b000) begin errors++; $display("FAIL reset_bus: got %b expected 000", {cyc, stb, we}); end
        checks++; if (adr !== 5'd0) begin errors++; $display("FAIL reset_adr: got %0h expected 0", adr); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %0h expected 0", dat_o); end
        checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL reset_sel: got %b expected 0000", sel); end
        checks++; if ({done, err, lerr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {done, err, lerr}); end
        checks++; if (echo_cnt !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", echo_cnt); end
    endtask

    task automatic test_config();
        logic [4:0] ea [6];
        logic [7:0] ed [6];
        int n;
        ea = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2, 5'd1};
        ed = '{8'h83, DIV[7:0], DIV[15:8], 8'h03, 8'h07, 8'h00};
        mute = 1'b0; rand_wait = 1'b0; wait_n = 1; force_en = 1'b0;
        rx_load_q.delete();
        do_reset(1'b0);
        tick();
        checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL cfg_first_cyc: got %b expected 1", cyc); end
        n = 0;
        while (log_q.size() < 6 && n < 500) begin tick(); n++; end
        checks++; if (log_q.size() < 6) begin errors++; $display("FAIL cfg_wait: got %0d accesses expected 6", log_q.size()); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cfg_done_early: got %b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cfg_done_rise: got %b expected 1", done); end
        if (log_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_q[i].we !== 1'b1 || log_q[i].adr !== ea[i] || log_q[i].dw !== {4{ed[i]}}
                    || log_q[i].sel !== (4'b0001 << ea[i][1:0])) begin
                    errors++;
                    $display("FAIL cfg_write[%0d]: got we %b adr %0d dat %h sel %b expected we 1 adr %0d dat %h sel %b",
                             i, log_q[i].we, log_q[i].adr, log_q[i].dw, log_q[i].sel, ea[i], {4{ed[i]}}, 4'b0001 << ea[i][1:0]);
                end
            end
        end
        repeat (50) tick();
        checks++; if (log_q.size() != 6) begin errors++; $display("FAIL cfg_idle: got %0d accesses expected 6", log_q.size()); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cfg_done_hold: got %b expected 1", done); end
    endtask

    task automatic test_echo();
        int n, nb, occ, ek, ak;
        mute = 1'b0; rand_wait = 1'b1; force_en = 1'b0;
        rx_load_q.delete();
        for (int i = 0; i < 5; i++) rx_load_q.push_back(8'h41 + 8'(i));
        for (int i = 0; i < 19; i++) rx_load_q.push_back(8'($urandom()));
        nb = rx_load_q.size();
        do_reset(1'b1);
        n = 0;
        while (tx_q.size() < nb && n < 20000) begin tick(); n++; end
        tick();
        checks++; if (tx_q.size() != nb) begin errors++; $display("FAIL echo_len: got %0d expected %0d", tx_q.size(), nb); end
        for (int i = 0; i < nb && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== rx_load_q[i]) begin errors++; $display("FAIL echo_byte[%0d]: got %h expected %h", i, tx_q[i], rx_load_q[i]); end
        end
        checks++; if (echo_cnt !== 16'(nb)) begin errors++; $display("FAIL echo_count: got %0d expected %0d", echo_cnt, nb); end
        checks++; if ({lerr, err} !== 2'b00) begin errors++; $display("FAIL echo_flags: got %b expected 00", {lerr, err}); end
        occ = 0;
        for (int i = 6; i < log_q.size(); i++) begin
            if (kind_of(log_q[i]) == 1) occ++;
            else if (kind_of(log_q[i]) == 2) occ--;
            else if (kind_of(log_q[i]) == 0 && i + 1 < log_q.size()) begin
                if (log_q[i].rd[5] && occ > 0) ek = 2;
                else if (log_q[i].rd[0] && occ < BUF_DEPTH) ek = 1;
                else ek = 0;
                ak = kind_of(log_q[i + 1]);
                checks++;
                if (ak != ek) begin
                    errors++;
                    $display("FAIL echo_decision[%0d]: got kind %0d expected kind %0d (lsr %h, fifo %0d)", i, ak, ek, log_q[i].rd, occ);
                end
            end
        end
    endtask

    task automatic test_full_priority();
        int nr, nw, first;
        logic [7:0] rdv[$];
        logic [7:0] wrv[$];
        mute = 1'b0; rand_wait = 1'b0; wait_n = 0; force_en = 1'b1; force_lsr = 8'h01;
        rbr_seed = 8'($urandom());
        do_reset(1'b1);
        repeat (300) tick();
        nr = 0; nw = 0;
        for (int i = 6; i < log_q.size(); i++) begin
            if (kind_of(log_q[i]) == 1) nr++;
            if (kind_of(log_q[i]) == 2) nw++;
        end
        checks++; if (nr != BUF_DEPTH) begin errors++; $display("FAIL full_reads: got %0d expected %0d", nr, BUF_DEPTH); end
        checks++; if (nw != 0) begin errors++; $display("FAIL full_writes: got %0d expected 0", nw); end
        checks++; if (kind_of(log_q[log_q.size() - 1]) != 0) begin errors++; $display("FAIL full_polling: got kind %0d expected 0", kind_of(log_q[log_q.size() - 1])); end
        first = log_q.size();
        force_lsr = 8'h61;
        repeat (300) tick();
        force_lsr = 8'h00;
        repeat (10) tick();
        ak_loop: for (int i = first; i < log_q.size(); i++) begin
            if (kind_of(log_q[i]) != 0) begin
                checks++;
                if (kind_of(log_q[i]) != 2) begin errors++; $display("FAIL prio_first: got kind %0d expected 2", kind_of(log_q[i])); end
                break;
            end
        end
        for (int i = 6; i < log_q.size(); i++) begin
            if (kind_of(log_q[i]) == 1) rdv.push_back(log_q[i].rd);
            if (kind_of(log_q[i]) == 2) wrv.push_back(log_q[i].dw[7:0]);
        end
        checks++; if (wrv.size() < BUF_DEPTH) begin errors++; $display("FAIL prio_writes: got %0d expected at least %0d", wrv.size(), BUF_DEPTH); end
        for (int k = 0; k < wrv.size() && k < rdv.size(); k++) begin
            checks++;
            if (wrv[k] !== rdv[k]) begin errors++; $display("FAIL prio_order[%0d]: got %h expected %h", k, wrv[k], rdv[k]); end
        end
        checks++; if (echo_cnt !== 16'(wrv.size())) begin errors++; $display("FAIL prio_count: got %0d expected %0d", echo_cnt, wrv.size()); end
    endtask

    task automatic test_line_err();
        logic [7:0] bad;
        int n;
        bit seen;
        for (int k = 0; k < 2; k++) begin
            mute = 1'b0; rand_wait = 1'b1; force_en = 1'b1; force_lsr = 8'h60;
            do_reset(1'b1);
            repeat (100) tick();
            checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL lerr_clean[%0d]: got %b expected 0", k, lerr); end
            bad = (k == 0) ? 8'h02 : (8'h01 << $urandom_range(2, 4));
            force_lsr = bad;
            n = 0; seen = 1'b0;
            while (!seen && n < 200) begin
                tick(); n++;
                if (log_q.size() > 0 && kind_of(log_q[log_q.size() - 1]) == 0 && log_q[log_q.size() - 1].rd == bad) seen = 1'b1;
            end
            force_lsr = 8'h60;
            checks++; if (!seen) begin errors++; $display("FAIL lerr_poll[%0d]: got no LSR read expected one", k); end
            tick();
            checks++; if (lerr !== 1'b1) begin errors++; $display("FAIL lerr_set[%0d]: got %b expected 1 (lsr %h)", k, lerr, bad); end
            repeat (100) tick();
            checks++; if (lerr !== 1'b1) begin errors++; $display("FAIL lerr_sticky[%0d]: got %b expected 1", k, lerr); end
        end
    endtask

    task automatic test_timeout();
        int n, hi, late;
        mute = 1'b1; rand_wait = 1'b0; force_en = 1'b0;
        do_reset(1'b1);
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b expected 0", err); end
        n = 0; hi = 0;
        while (cyc && n < 2000) begin hi++; tick(); n++; end
        checks++; if (hi != TIMEOUT) begin errors++; $display("FAIL tmo_cycles: got %0d expected %0d", hi, TIMEOUT); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tmo_done: got %b expected 0", done); end
        late = 0;
        repeat (1000) begin tick(); if (cyc !== 1'b0) late++; end
        checks++; if (late != 0) begin errors++; $display("FAIL tmo_halt: got %0d busy cycles expected 0", late); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", err); end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        mute = 1'b0; rand_wait = 1'b0; wait_n = 2; force_en = 1'b1; force_lsr = 8'h61;
        do_reset(1'b1);
        n = 0;
        while (echo_cnt < 16'd2 && n < 2000) begin tick(); n++; end
        checks++; if (echo_cnt < 16'd2) begin errors++; $display("FAIL mid_progress: got %0d expected at least 2", echo_cnt); end
        n = 0;
        while (!(cyc && !we && adr == 5'd0) && n < 200) begin tick(); n++; end
        checks++; if (!(cyc && !we && adr == 5'd0)) begin errors++; $display("FAIL mid_find_read: got cyc %b we %b adr %0d expected RBR read", cyc, we, adr); end
        rst_n = 1'b0;
        #1;
        checks++; if ({cyc, stb, we} !== 3'b000) begin errors++; $display("FAIL mid_async_drop: got %b expected 000", {cyc, stb, we}); end
        repeat (3) tick();
        checks++; if (echo_cnt !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", echo_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cyc !== 1'b1 || we !== 1'b1 || adr !== 5'd3 || dat_o !== 32'h83838383) begin
            errors++;
            $display("FAIL mid_restart: got cyc %b we %b adr %0d dat %h expected cyc 1 we 1 adr 3 dat 83838383", cyc, we, adr, dat_o);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_echo();
        test_full_priority();
        test_line_err();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
